// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller: FSM encoding, blank code, clog2 helper.
// Optional leading-zero blanking is enabled with the SEG_LZB_EN macro.
package seg_pkg;

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    function automatic int seg_clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seg_lzb.sv
// Combinational leading-zero blanker: digits above the highest non-zero digit become BLANK_CODE.
// Instantiated by seg_scan_ctrl only when SEG_LZB_EN is defined; digit 0 always passes through.
module seg_lzb
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8
) (
    input  logic [4*NUM_DIGITS-1:0] digits,
    output logic [4*NUM_DIGITS-1:0] blanked
);

    // keep[i] is set when digit i or any digit above it is non-zero
    logic [NUM_DIGITS:1] keep;

    assign keep[NUM_DIGITS] = 1'b0;
    assign blanked[3:0]     = digits[3:0];

    genvar gi;
    generate
        for (gi = NUM_DIGITS - 1; gi >= 1; gi--) begin : g_digit
            assign keep[gi] = keep[gi+1] | (digits[4*gi +: 4] != 4'd0);
            assign blanked[4*gi +: 4] = keep[gi] ? digits[4*gi +: 4] : BLANK_CODE;
        end
    endgenerate

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan controller for an N-digit common-anode 7-segment display with blanking gaps
// and frame-boundary commits. Define SEG_LZB_EN to apply leading-zero blanking at commit.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DIV          = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   sel_n,
    output logic                    frame_start
);

    localparam int CNT_MAX = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
    localparam int CNT_W   = seg_clog2(CNT_MAX + 1);
    localparam int IDX_W   = seg_clog2(NUM_DIGITS);
    localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [1:0]       ST_FIRST   = HAS_BLANK ? ST_BLANK : ST_SHOW;

    logic [1:0]       state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             commit;

    logic [NUM_DIGITS-1:0][3:0] shadow_reg, shadow_next;
    logic [NUM_DIGITS-1:0][3:0] pending_reg;
    logic                       pend_vld_reg;
    logic [4*NUM_DIGITS-1:0]    commit_frame;

    logic [3:0]            bcd_next;
    logic [NUM_DIGITS-1:0] sel_next;

`ifdef SEG_LZB_EN
    seg_lzb #(
        .NUM_DIGITS(NUM_DIGITS)
    ) u_lzb (
        .digits (pending_reg),
        .blanked(commit_frame)
    );
`else
    assign commit_frame = pending_reg;
`endif

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        commit     = 1'b0;
        if (!en) begin
            state_next = ST_OFF;
            idx_next   = '0;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ST_OFF: begin
                    state_next = ST_FIRST;
                    idx_next   = '0;
                    cnt_next   = '0;
                    commit     = 1'b1;
                end
                ST_BLANK: begin
                    if (cnt_reg == BLANK_LAST) begin
                        state_next = ST_SHOW;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt_reg == SHOW_LAST) begin
                        state_next = ST_FIRST;
                        cnt_next   = '0;
                        if (idx_reg == IDX_LAST) begin
                            idx_next = '0;
                            commit   = 1'b1;
                        end else begin
                            idx_next = idx_reg + 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = ST_OFF;
                    idx_next   = '0;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Outputs are derived from the next-state values so they line up with the registered state.
    always_comb begin
        shadow_next = (commit && pend_vld_reg) ? commit_frame : shadow_reg;
        bcd_next    = (state_next == ST_OFF) ? BLANK_CODE : shadow_next[idx_next];
        sel_next    = '1;
        if (state_next == ST_SHOW) begin
            sel_next[idx_next] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_OFF;
            idx_reg      <= '0;
            cnt_reg      <= '0;
            shadow_reg   <= {NUM_DIGITS{BLANK_CODE}};
            pending_reg  <= {NUM_DIGITS{BLANK_CODE}};
            pend_vld_reg <= 1'b0;
            bcd_out      <= BLANK_CODE;
            sel_n        <= '1;
            frame_start  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            cnt_reg     <= cnt_next;
            shadow_reg  <= shadow_next;
            bcd_out     <= bcd_next;
            sel_n       <= sel_next;
            frame_start <= commit;
            // A load on the commit edge lands after the old pending frame was taken.
            if (load) begin
                pending_reg  <= digits_in;
                pend_vld_reg <= 1'b1;
            end else if (commit) begin
                pend_vld_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, DIV=4, BLANK_CYCLES=2) plus a no-blank instance.
// Expected outputs come from a frame-time model; build with SEG_LZB_EN to cover leading-zero blanking.
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int DV    = 4;
    localparam int BC    = 2;
    localparam int DPER  = DV + BC;
    localparam int FPER  = ND * DPER;
    localparam int FPER0 = ND * DV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  bcd_out, bcd_out0;
    logic [3:0]  sel_n, sel_n0;
    logic        frame_start, frame_start0;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    seg_scan_ctrl #(.NUM_DIGITS(ND), .DIV(DV), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
        .bcd_out(bcd_out), .sel_n(sel_n), .frame_start(frame_start)
    );

    seg_scan_ctrl #(.NUM_DIGITS(ND), .DIV(DV), .BLANK_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
        .bcd_out(bcd_out0), .sel_n(sel_n0), .frame_start(frame_start0)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_run = 1'b0;
    int          m_t   = 0;
    logic [15:0] m_shadow = 16'hFFFF;
    logic [15:0] m_pend   = 16'hFFFF;
    bit          m_pv     = 1'b0;
    logic [3:0]  e_bcd, e_sel, e_sel0;
    logic        e_fs, e_fs0;

    function automatic logic [15:0] commit_model(input logic [15:0] f);
        logic [15:0] r;
        int h;
        r = f;
        h = 0;
`ifdef SEG_LZB_EN
        for (int i = 0; i < ND; i++) if (f[4*i +: 4] != 4'd0) h = i;
        for (int i = 1; i < ND; i++) if (i > h) r[4*i +: 4] = 4'hF;
`endif
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_run = 1'b0; m_t = 0; m_shadow = 16'hFFFF; m_pend = 16'hFFFF; m_pv = 1'b0;
        end else begin
            if (!en) begin
                m_run = 1'b0;
            end else begin
                if (!m_run) begin m_run = 1'b1; m_t = 0; end
                else m_t = m_t + 1;
                if ((m_t % FPER) == 0 && m_pv) begin
                    m_shadow = commit_model(m_pend);
                    m_pv = 1'b0;
                end
            end
            if (load) begin m_pend = digits_in; m_pv = 1'b1; end
        end
        if (!m_run) begin
            e_bcd = 4'hF; e_sel = 4'hF; e_fs = 1'b0; e_sel0 = 4'hF; e_fs0 = 1'b0;
        end else begin
            e_bcd  = m_shadow[4*((m_t % FPER) / DPER) +: 4];
            e_sel  = ((m_t % DPER) < BC) ? 4'hF : ~(4'b0001 << ((m_t % FPER) / DPER));
            e_fs   = ((m_t % FPER) == 0);
            e_sel0 = ~(4'b0001 << ((m_t % FPER0) / DV));
            e_fs0  = ((m_t % FPER0) == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d: got %0h expected %0h", name, m_t, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_bcd", 32'(bcd_out), 32'(e_bcd));
            chk("model_sel", 32'(sel_n), 32'(e_sel));
            chk("model_fs", 32'(frame_start), 32'(e_fs));
            chk("model_sel0", 32'(sel_n0), 32'(e_sel0));
            chk("model_fs0", 32'(frame_start0), 32'(e_fs0));
        end
    end

    initial begin
        @(posedge clk);
        chk_on = 1'b1;
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [3:0] s, input logic [3:0] b, input logic f);
        chk({name, "_sel"}, 32'(sel_n), 32'(s));
        chk({name, "_bcd"}, 32'(bcd_out), 32'(b));
        chk({name, "_fs"}, 32'(frame_start), 32'(f));
        $display("txn %s: sel_n=%b bcd=%h fs=%b", name, sel_n, bcd_out, frame_start);
    endtask

    task automatic do_load(input logic [15:0] d);
        load = 1'b1; digits_in = d;
        step(1);
        load = 1'b0;
    endtask

    logic [3:0] lzb_zero;

    initial begin
`ifdef SEG_LZB_EN
        lzb_zero = 4'hF;
`else
        lzb_zero = 4'h0;
`endif
        rst_n = 1'b0; en = 1'b1; load = 1'b0; digits_in = 16'h0;
        step(3);
        lit("reset", 4'hF, 4'hF, 1'b0);

        rst_n = 1'b1; en = 1'b0; load = 1'b1; digits_in = 16'h4321;
        step(1);
        load = 1'b0; en = 1'b1;
        step(1);  lit("scan_t0", 4'hF, 4'h1, 1'b1);
        step(2);  lit("scan_d0", 4'hE, 4'h1, 1'b0);
                  chk("nb_d0_sel", 32'(sel_n0), 32'hE);
        step(6);  lit("scan_d1", 4'hD, 4'h2, 1'b0);
                  chk("nb_d2_sel", 32'(sel_n0), 32'hB);
        step(12); lit("scan_d3", 4'h7, 4'h4, 1'b0);
        step(4);  lit("scan_wrap", 4'hF, 4'h1, 1'b1);
        step(2);  lit("scan_wrap_d0", 4'hE, 4'h1, 1'b0);

        step(12); lit("midload_d2", 4'hB, 4'h3, 1'b0);   // t=38
        do_load(16'h9876);
        step(5);  lit("midload_d3", 4'h7, 4'h4, 1'b0);   // t=44
        step(6);  lit("newframe_d0", 4'hE, 4'h6, 1'b0);  // t=50
        step(6);  lit("newframe_d1", 4'hD, 4'h7, 1'b0);
        step(6);  lit("newframe_d2", 4'hB, 4'h8, 1'b0);
        step(6);  lit("newframe_d3", 4'h7, 4'h9, 1'b0);  // t=68

        step(6);  do_load(16'h1111);                     // t=74 -> 75
        step(5);  do_load(16'h2222);                     // t=80 -> 81
        step(17); lit("lastwins_d0", 4'hE, 4'h2, 1'b0);  // t=98
        step(6);  lit("lastwins_d1", 4'hD, 4'h2, 1'b0);  // t=104

        step(6);  do_load(16'h3456);                     // t=110 -> 111
        step(8);  do_load(16'h7777);                     // load sampled on commit edge t=120
        lit("samecommit_fs", 4'hF, 4'h6, 1'b1);
        step(2);  lit("samecommit_d0", 4'hE, 4'h6, 1'b0); // t=122
        step(24); lit("nextframe_d0", 4'hE, 4'h7, 1'b0);  // t=146

        step(6);  lit("pre_off_d1", 4'hD, 4'h7, 1'b0);    // t=152
        en = 1'b0;
        step(1);  lit("off", 4'hF, 4'hF, 1'b0);
        step(2);  en = 1'b1;
        step(1);  lit("restart", 4'hF, 4'h7, 1'b1);
        step(2);  lit("restart_d0", 4'hE, 4'h7, 1'b0);    // t=2

        do_load(16'h0050);                                // t=3
        step(23); lit("lzb_d0", 4'hE, 4'h0, 1'b0);        // t=26
        step(6);  lit("lzb_d1", 4'hD, 4'h5, 1'b0);
        step(6);  lit("lzb_d2", 4'hB, lzb_zero, 1'b0);
        step(6);  lit("lzb_d3", 4'h7, lzb_zero, 1'b0);    // t=44
        do_load(16'h0000);                                // t=45
        step(5);  lit("zero_d0", 4'hE, 4'h0, 1'b0);       // t=50
        step(6);  lit("zero_d1", 4'hD, lzb_zero, 1'b0);   // t=56

        rst_n = 1'b0;
        step(1);  lit("midreset", 4'hF, 4'hF, 1'b0);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
